// File: rtl/ayatsuki_bus_fabric_pkg.sv
// ayatsuki_bus_fabric_pkg
//   Shared definitions for the system-bus fabric: FSM state encoding, the
//   read-data value returned with an error response, the default bus
//   timeout and a helper that sizes slave-index signals.
package ayatsuki_bus_fabric_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_W = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_ERR_W  = 3'd3,
    ST_ERR_R  = 3'd4
  } fab_state_e;

  localparam int   DEFAULT_TIMEOUT = 16;
  // Every bit of m_r_data takes this value on an error response.
  localparam logic ERR_RDATA_BIT   = 1'b0;

  // Width of a slave index; a single-slave fabric still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ayatsuki_bus_fabric_addr_decoder.sv
// ayatsuki_bus_fabric_addr_decoder
//   Combinational priority decode of a byte address against the packed
//   base/mask map. Slave i hits when (addr & mask_i) == base_i; on overlap
//   the lowest index wins.
// Ports:
//   addr_i  address to decode
//   hit_o   at least one slave matches
//   idx_o   index of the winning slave (0 when no hit)
module ayatsuki_bus_fabric_addr_decoder
  import ayatsuki_bus_fabric_pkg::*;
#(
  parameter int                      N_SLV    = 4,
  parameter int                      ADDR_W   = 32,
  parameter int                      SEL_W    = 2,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  idx_o
);

  logic [N_SLV-1:0] match;

  generate
    for (genvar gi = 0; gi < N_SLV; gi++) begin : g_match
      assign match[gi] = (addr_i & SLV_MASK[gi*ADDR_W +: ADDR_W])
                         == SLV_BASE[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Scan from the top down so the last assignment is the lowest hit index.
  always_comb begin
    hit_o = |match;
    idx_o = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (match[i]) idx_o = SEL_W'(i);
    end
  end

endmodule

// File: rtl/ayatsuki_bus_fabric.sv
// ayatsuki_bus_fabric
//   Interconnect between the core's split read/write port and N_SLV
//   memory-mapped slaves. One transfer is in flight at a time; writes win
//   over reads in IDLE. Slaves insert wait states by holding s_ready low;
//   unmapped addresses and slaves silent for TIMEOUT cycles get an error.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   m_w_enable/m_w_addr/m_w_data    master write request (held until ack)
//   m_r_enable/m_r_addr             master read request (held until ack)
//   m_w_ack, m_r_ack, m_err         completion pulses, error flag with ack
//   m_r_data                        read data, valid with m_r_ack, else 0
//   s_w_enable, s_r_enable          one-hot slave strobes (one cycle)
//   s_addr, s_w_data                shared slave address / write data
//   s_r_data, s_ready               packed slave read data, slave done
module ayatsuki_bus_fabric
  import ayatsuki_bus_fabric_pkg::*;
#(
  parameter int                      N_SLV    = 4,
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int                      TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_w_enable,
  input  logic [ADDR_W-1:0]       m_w_addr,
  input  logic [DATA_W-1:0]       m_w_data,
  input  logic                    m_r_enable,
  input  logic [ADDR_W-1:0]       m_r_addr,
  output logic                    m_w_ack,
  output logic                    m_r_ack,
  output logic [DATA_W-1:0]       m_r_data,
  output logic                    m_err,
  output logic [N_SLV-1:0]        s_w_enable,
  output logic [N_SLV-1:0]        s_r_enable,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_w_data,
  input  logic [N_SLV*DATA_W-1:0] s_r_data,
  input  logic [N_SLV-1:0]        s_ready
);

  localparam int SEL_W = sel_width(N_SLV);
  localparam int CNT_W = $clog2(TIMEOUT);

  fab_state_e          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   rdata_arr [N_SLV];
  logic [ADDR_W-1:0]   dec_addr;
  logic                dec_hit;
  logic [SEL_W-1:0]    dec_idx;
  logic                sel_ready;
  logic                timed_out;

  generate
    for (genvar gi = 0; gi < N_SLV; gi++) begin : g_rdata
      assign rdata_arr[gi] = s_r_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // One decoder serves both directions; the write address is decoded
  // whenever a write is pending because writes take priority.
  assign dec_addr = m_w_enable ? m_w_addr : m_r_addr;

  ayatsuki_bus_fabric_addr_decoder #(
    .N_SLV    (N_SLV),
    .ADDR_W   (ADDR_W),
    .SEL_W    (SEL_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decoder (
    .addr_i (dec_addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign sel_ready = s_ready[sel_q];
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m_w_ack    = 1'b0;
    m_r_ack    = 1'b0;
    m_err      = 1'b0;
    m_r_data   = '0;
    s_w_enable = '0;
    s_r_enable = '0;
    s_addr     = addr_q;
    s_w_data   = wdata_q;

    case (state_q)
      ST_IDLE: begin
        // Requests are not accepted while reset is held so every output
        // stays quiet even if the master keeps its enable asserted.
        if (!rst) begin
          if (m_w_enable) begin
            addr_d   = m_w_addr;
            wdata_d  = m_w_data;
            s_addr   = m_w_addr;
            s_w_data = m_w_data;
            sel_d    = dec_idx;
            cnt_d    = '0;
            if (dec_hit) begin
              s_w_enable[dec_idx] = 1'b1;
              state_d             = ST_WAIT_W;
            end else begin
              state_d = ST_ERR_W;
            end
          end else if (m_r_enable) begin
            addr_d = m_r_addr;
            s_addr = m_r_addr;
            sel_d  = dec_idx;
            cnt_d  = '0;
            if (dec_hit) begin
              s_r_enable[dec_idx] = 1'b1;
              state_d             = ST_WAIT_R;
            end else begin
              state_d = ST_ERR_R;
            end
          end
        end
      end

      ST_WAIT_W, ST_WAIT_R: begin
        // A ready arriving on the last allowed cycle still completes cleanly.
        if (sel_ready || timed_out) begin
          m_w_ack = (state_q == ST_WAIT_W);
          m_r_ack = (state_q == ST_WAIT_R);
          m_err   = !sel_ready;
          if (state_q == ST_WAIT_R) begin
            m_r_data = sel_ready ? rdata_arr[sel_q] : {DATA_W{ERR_RDATA_BIT}};
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ERR_W: begin
        m_w_ack = 1'b1;
        m_err   = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ERR_R: begin
        m_r_ack  = 1'b1;
        m_err    = 1'b1;
        m_r_data = {DATA_W{ERR_RDATA_BIT}};
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ayatsuki_bus_fabric.sv
module tb_ayatsuki_bus_fabric;

  localparam int N_SLV   = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  // Map: slave0 0x0000-0x0FFF, slave1 0x2000-0x2FFF, slave2 0x2000-0x3FFF
  // (slave2 loses the overlap to slave1); everything else is unmapped.
  localparam logic [N_SLV*AW-1:0] BASE = {32'h0000_2000, 32'h0000_2000, 32'h0000_0000};
  localparam logic [N_SLV*AW-1:0] MASK = {32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic              clk = 1'b0;
  logic              rst;
  logic              m_w_enable, m_r_enable;
  logic [AW-1:0]     m_w_addr, m_r_addr;
  logic [DW-1:0]     m_w_data;
  logic              m_w_ack, m_r_ack, m_err;
  logic [DW-1:0]     m_r_data;
  logic [N_SLV-1:0]  s_w_enable, s_r_enable, s_ready;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_w_data;
  logic [N_SLV*DW-1:0] s_r_data;

  ayatsuki_bus_fabric #(
    .N_SLV(N_SLV), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .m_w_enable(m_w_enable), .m_w_addr(m_w_addr), .m_w_data(m_w_data),
    .m_r_enable(m_r_enable), .m_r_addr(m_r_addr),
    .m_w_ack(m_w_ack), .m_r_ack(m_r_ack), .m_r_data(m_r_data), .m_err(m_err),
    .s_w_enable(s_w_enable), .s_r_enable(s_r_enable),
    .s_addr(s_addr), .s_w_data(s_w_data),
    .s_r_data(s_r_data), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_rd; bit err; logic [31:0] rdata; int cyc; logic [31:0] addr; } exp_t;
  typedef struct { bit is_rd; int sl; logic [31:0] addr; logic [31:0] wd; } strb_t;
  typedef struct { int lat; logic [31:0] rd; } slv_t;

  exp_t  exp_q[$];
  strb_t strb_q[$];
  slv_t  slv_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    txn    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Address map as plain ranges.
  function automatic int ref_decode(input logic [31:0] a);
    if (a < 32'h1000) return 0;
    if (a >= 32'h2000 && a < 32'h3000) return 1;
    if (a >= 32'h3000 && a < 32'h4000) return 2;
    return -1;
  endfunction

  // Queue the expected response of a transfer accepted at cycle t; returns
  // the cycle in which its ack is expected.
  function automatic int push_exp(input bit is_rd, input logic [31:0] addr,
                                  input logic [31:0] wd, input int lat,
                                  input logic [31:0] rd, input int t);
    exp_t  e;
    strb_t s;
    slv_t  v;
    int    sl;
    sl      = ref_decode(addr);
    e.is_rd = is_rd;
    e.addr  = addr;
    e.rdata = 32'h0;
    if (sl < 0) begin
      e.err = 1'b1;
      e.cyc = t + 1;
    end else begin
      s.is_rd = is_rd; s.sl = sl; s.addr = addr; s.wd = wd;
      strb_q.push_back(s);
      v.lat = lat; v.rd = rd;
      slv_q.push_back(v);
      if (lat <= TIMEOUT - 1) begin
        e.err = 1'b0;
        e.cyc = t + 1 + lat;
        if (is_rd) e.rdata = rd;
      end else begin
        e.err = 1'b1;
        e.cyc = t + TIMEOUT;
      end
    end
    exp_q.push_back(e);
    return e.cyc;
  endfunction

  // Slave responder: consumes strobes, checks them, and produces s_ready
  // after the programmed number of wait cycles. Non-selected ready bits
  // and read-data lanes carry random noise.
  initial begin
    bit          busy = 1'b0;
    int          sel = 0, rem = 0;
    logic [31:0] b_rd = 0, b_addr = 0, b_wd = 0;
    bit          b_rdk = 1'b0;
    s_ready  = '0;
    s_r_data = '0;
    forever begin
      bit new_strobe;
      new_strobe = 1'b0;
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (m_w_ack || m_r_ack) busy = 1'b0;
        if (s_w_enable != '0 || s_r_enable != '0) begin
          checks++;
          if (busy || strb_q.size() == 0 || slv_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected actual w=%b r=%b addr=%h required no strobe",
                     s_w_enable, s_r_enable, s_addr);
          end else begin
            strb_t s;
            slv_t  v;
            logic [N_SLV-1:0] ew, er;
            s = strb_q.pop_front();
            v = slv_q.pop_front();
            ew = '0; er = '0;
            if (s.is_rd) er[s.sl] = 1'b1; else ew[s.sl] = 1'b1;
            if (s_w_enable !== ew || s_r_enable !== er || s_addr !== s.addr ||
                (!s.is_rd && s_w_data !== s.wd)) begin
              errors++;
              $display("FAIL strobe actual w=%b r=%b addr=%h wd=%h required w=%b r=%b addr=%h wd=%h",
                       s_w_enable, s_r_enable, s_addr, s_w_data, ew, er, s.addr, s.wd);
            end
            busy = 1'b1; new_strobe = 1'b1;
            sel = s.sl; rem = v.lat; b_rd = v.rd;
            b_addr = s.addr; b_wd = s.wd; b_rdk = s.is_rd;
          end
        end else if (busy) begin
          checks++;
          if (s_addr !== b_addr || (!b_rdk && s_w_data !== b_wd)) begin
            errors++;
            $display("FAIL wait_hold actual addr=%h wd=%h required addr=%h wd=%h",
                     s_addr, s_w_data, b_addr, b_wd);
          end
        end
      end
      @(posedge clk);
      #1;
      begin
        logic [N_SLV-1:0] rdy;
        if (busy && !new_strobe) rem--;
        rdy = N_SLV'($urandom);
        for (int i = 0; i < N_SLV; i++) s_r_data[i*DW +: DW] = $urandom;
        if (busy) begin
          rdy[sel] = (rem == 0);
          s_r_data[sel*DW +: DW] = b_rd;
        end
        s_ready = rdy;
      end
    end
  end

  // Monitor: pops the scoreboard on every ack.
  initial forever begin
    @(negedge clk);
    if (m_w_ack || m_r_ack) begin
      checks++;
      if (m_w_ack && m_r_ack) begin
        errors++;
        $display("FAIL ack_both actual w_ack=1 r_ack=1 required one ack");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected actual r_ack=%0b err=%0b required no ack", m_r_ack, m_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d rd=%0b addr=%h err=%0b rdata=%h cyc=%0d",
                 txn, m_r_ack, e.addr, m_err, m_r_data, cyc);
        if (m_r_ack != e.is_rd || m_err !== e.err || m_r_data !== e.rdata || cyc != e.cyc) begin
          errors++;
          $display("FAIL ack addr=%h actual rd=%0b err=%0b rdata=%h cyc=%0d required rd=%0b err=%0b rdata=%h cyc=%0d",
                   e.addr, m_r_ack, m_err, m_r_data, cyc, e.is_rd, e.err, e.rdata, e.cyc);
        end
      end
    end else begin
      checks++;
      if (m_err !== 1'b0 || m_r_data !== '0) begin
        errors++;
        $display("FAIL idle_outputs actual err=%0b rdata=%h required err=0 rdata=0", m_err, m_r_data);
      end
    end
  end

  task automatic check_all_zero(input string name);
    checks++;
    if (m_w_ack !== 1'b0 || m_r_ack !== 1'b0 || m_err !== 1'b0 || s_w_enable !== '0 ||
        s_r_enable !== '0 || s_addr !== '0 || s_w_data !== '0 || m_r_data !== '0) begin
      errors++;
      $display("FAIL %s actual wack=%0b rack=%0b err=%0b sw=%b sr=%b addr=%h wd=%h rdata=%h required all 0",
               name, m_w_ack, m_r_ack, m_err, s_w_enable, s_r_enable, s_addr, s_w_data, m_r_data);
    end
  endtask

  task automatic wait_ack(input bit is_rd);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = is_rd ? m_r_ack : m_w_ack;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_ack actual no %s ack in 40 cycles required ack", is_rd ? "read" : "write");
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      m_w_enable = 1'b0;
      m_r_enable = 1'b0;
    end
  endtask

  task automatic issue(input bit is_rd, input logic [31:0] addr, input logic [31:0] wd,
                       input int lat, input logic [31:0] rd);
    @(posedge clk); #1;
    m_w_enable = !is_rd;
    m_r_enable = is_rd;
    if (is_rd) m_r_addr = addr;
    else begin m_w_addr = addr; m_w_data = wd; end
    void'(push_exp(is_rd, addr, wd, lat, rd, cyc));
    wait_ack(is_rd);
  endtask

  task automatic issue_both(input logic [31:0] wa, input logic [31:0] wd, input int wlat,
                            input logic [31:0] ra, input int rlat, input logic [31:0] rd);
    int wack;
    @(posedge clk); #1;
    m_w_enable = 1'b1; m_w_addr = wa; m_w_data = wd;
    m_r_enable = 1'b1; m_r_addr = ra;
    wack = push_exp(1'b0, wa, wd, wlat, 32'h0, cyc);
    void'(push_exp(1'b1, ra, 32'h0, rlat, rd, wack + 1));
    wait_ack(1'b0);
    @(posedge clk); #1;
    m_w_enable = 1'b0;
    wait_ack(1'b1);
  endtask

  task automatic reset_mid();
    logic [31:0] a;
    a = 32'h0000_2040;
    @(posedge clk); #1;
    m_w_enable = 1'b0; m_r_enable = 1'b1; m_r_addr = a;
    void'(push_exp(1'b1, a, 32'h0, 100, 32'hDEAD_BEEF, cyc));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset_mid");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    void'(push_exp(1'b1, a, 32'h0, 1, 32'h0BAD_F00D, cyc));
    wait_ack(1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 32'hFFF));
      1:       return 32'h1000 + 32'($urandom_range(0, 32'hFFF));
      2:       return 32'h2000 + 32'($urandom_range(0, 32'hFFF));
      3:       return 32'h3000 + 32'($urandom_range(0, 32'hFFF));
      default: return $urandom | 32'h8000_0000;
    endcase
  endfunction

  function automatic int rand_lat();
    if ($urandom_range(0, 9) < 7) return $urandom_range(0, 3);
    return $urandom_range(6, 9);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual simulation still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m_w_enable = 1'b0; m_r_enable = 1'b0;
    m_w_addr = '0; m_r_addr = '0; m_w_data = '0;
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset_state");
    end
    @(posedge clk); #1;
    rst = 1'b0;

    issue(1'b0, 32'h0000_0010, 32'h0000_00A5, 0, 32'h0);        // zero-wait write
    issue(1'b1, 32'h0000_2000, 32'h0, 3, 32'h1234_5678);        // 3 wait states
    issue(1'b1, 32'h8000_0000, 32'h0, 0, 32'h0);                // unmapped read
    issue(1'b0, 32'h0000_1800, 32'h5555_AAAA, 0, 32'h0);        // unmapped write
    issue(1'b1, 32'h0000_2100, 32'h0, 100, 32'hBEEF_0001);      // timeout
    issue(1'b1, 32'h0000_2104, 32'h0, 0, 32'hCAFE_0002);        // recovers
    issue(1'b1, 32'h0000_3004, 32'h0, TIMEOUT - 1, 32'h7777_0003); // last legal cycle
    issue(1'b0, 32'h0000_0004, 32'h1111_2222, TIMEOUT, 32'h0);  // one cycle too late
    issue(1'b0, 32'h0000_2F00, 32'h3333_4444, 0, 32'h0);        // overlap -> slave1
    issue(1'b0, 32'h0000_3F00, 32'h5555_6666, 0, 32'h0);        // slave2 only
    issue_both(32'h0000_3010, 32'hA0A0_B0B0, 0, 32'h0000_0020, 0, 32'h0F0F_1E1E);
    issue(1'b1, 32'h0000_0100, 32'h0, 0, 32'h0101_0101);        // back-to-back
    issue(1'b0, 32'h0000_0104, 32'h0202_0202, 0, 32'h0);
    issue(1'b1, 32'h0000_0108, 32'h0, 0, 32'h0303_0303);
    reset_mid();

    for (int i = 0; i < 60; i++) begin
      gap($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0)
        issue_both(rand_addr(), $urandom, rand_lat(), rand_addr(), rand_lat(), $urandom);
      else
        issue(1'($urandom), rand_addr(), $urandom, rand_lat(), $urandom);
    end

    gap(3);
    checks++;
    if (exp_q.size() != 0 || strb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover actual acks_pending=%0d strobes_pending=%0d required 0 0",
               exp_q.size(), strb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
